// File: rtl/audio_serial_receiver_pkg.sv
// Shared constants for the audio front-end: default widths, channel encoding,
// and bit positions of the raw serial bus inside the synchroniser bundle.
package audio_serial_receiver_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 16;
  localparam int DEFAULT_SYNC_STAGES = 2;

  localparam logic CH_LEFT  = 1'b1;
  localparam logic CH_RIGHT = 1'b0;

  localparam int BUS_WIDTH = 3;
  localparam int BUS_LRCLK = 2;
  localparam int BUS_SCLK  = 1;
  localparam int BUS_SDIN  = 0;

  // lr_level is the word-clock level that was present while the word arrived.
  function automatic logic channel_of(input logic lr_level, input logic polarity);
    return ((lr_level ^ polarity) == 1'b0) ? CH_LEFT : CH_RIGHT;
  endfunction

endpackage

// File: rtl/audio_input_sync.sv
// Multi-bit level synchroniser for the raw serial bus, plus a rising-edge pulse
// on one selected bit. Every bit sees the same delay, so relative phase is kept.
module audio_input_sync
  import audio_serial_receiver_pkg::*;
#(
  parameter int WIDTH    = BUS_WIDTH,
  parameter int STAGES   = DEFAULT_SYNC_STAGES,
  parameter int RISE_BIT = BUS_SCLK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync,
  output logic             o_rise
);

  // Fewer than two stages would not give metastability protection.
  localparam int DEPTH = (STAGES < 2) ? 2 : STAGES;

  logic [WIDTH-1:0] r_stage [DEPTH];
  logic             r_rise_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
      r_rise_d <= 1'b0;
    end else begin
      r_stage[0] <= i_async;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
      r_rise_d <= r_stage[DEPTH-1][RISE_BIT];
    end
  end

  assign o_sync = r_stage[DEPTH-1];
  assign o_rise = o_sync[RISE_BIT] & ~r_rise_d;

endmodule

// File: rtl/audio_serial_receiver.sv
// Serial audio receiver: synchronises lrclk/sclk/sdin, assembles MSB-first words
// in left-justified or I2S framing and emits one channel-tagged sample per word.
module audio_serial_receiver
  import audio_serial_receiver_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lrclk,
  input  logic                  sclk,
  input  logic                  sdin,
  input  logic                  is_data_delay,
  input  logic                  lrclk_polarity,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_is_left,
  output logic                  out_valid,
  output logic                  overflow
);

  // Output handshake: out_valid is a one-cycle strobe with no backpressure;
  // out_data/out_is_left are valid in that cycle and held until the next commit.

  localparam int CW = $clog2(DATA_WIDTH + 2);
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t CNT_FULL = cnt_t'(DATA_WIDTH);
  localparam cnt_t CNT_SAT  = cnt_t'(DATA_WIDTH + 1);
  localparam cnt_t MSB_POS  = cnt_t'(DATA_WIDTH - 1);

  logic [BUS_WIDTH-1:0]  w_async;
  logic [BUS_WIDTH-1:0]  w_sync;
  logic                  w_sclk_rise;
  logic                  w_s_lrclk;
  logic                  w_s_sdin;
  logic                  w_boundary;
  logic                  w_room;
  cnt_t                  w_pos;
  logic [DATA_WIDTH-1:0] w_placed;
  logic [DATA_WIDTH-1:0] w_appended;
  logic [DATA_WIDTH-1:0] w_new_word;

  logic [DATA_WIDTH-1:0] r_shift;
  cnt_t                  r_count;
  logic                  r_lr_prev;
  logic                  r_armed;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_is_left;
  logic                  r_valid;
  logic                  r_overflow;

  assign w_async[BUS_LRCLK] = lrclk;
  assign w_async[BUS_SCLK]  = sclk;
  assign w_async[BUS_SDIN]  = sdin;

  audio_input_sync #(
    .WIDTH    (BUS_WIDTH),
    .STAGES   (SYNC_STAGES),
    .RISE_BIT (BUS_SCLK)
  ) u_input_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (w_async),
    .o_sync  (w_sync),
    .o_rise  (w_sclk_rise)
  );

  assign w_s_lrclk  = w_sync[BUS_LRCLK];
  assign w_s_sdin   = w_sync[BUS_SDIN];
  assign w_boundary = w_s_lrclk ^ r_lr_prev;
  assign w_room     = (r_count < CNT_FULL);

  // Bit n of the word (n = 0 is the MSB) lands at position DATA_WIDTH-1-n.
  assign w_pos      = MSB_POS - r_count;
  assign w_placed   = w_room ? (DATA_WIDTH'(w_s_sdin) << w_pos) : '0;
  assign w_appended = r_shift | w_placed;
  assign w_new_word = {w_s_sdin, {(DATA_WIDTH-1){1'b0}}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift    <= '0;
      r_count    <= '0;
      r_lr_prev  <= 1'b0;
      r_armed    <= 1'b0;
      r_data     <= '0;
      r_is_left  <= 1'b0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_sclk_rise) begin
        r_lr_prev <= w_s_lrclk;
        if (w_boundary) begin
          r_armed <= 1'b1;
          // The very first boundary only aligns to the frame; its partial word is dropped.
          if (r_armed) begin
            r_data    <= is_data_delay ? w_appended : r_shift;
            r_is_left <= channel_of(r_lr_prev, lrclk_polarity);
            r_valid   <= 1'b1;
          end
          if (is_data_delay) begin
            // In I2S the boundary bit is the LSB of the word being closed.
            if (!w_room) begin
              r_overflow <= 1'b1;
            end
            r_shift <= '0;
            r_count <= '0;
          end else begin
            r_shift <= w_new_word;
            r_count <= cnt_t'(1);
          end
        end else if (w_room) begin
          r_shift <= w_appended;
          r_count <= r_count + cnt_t'(1);
        end else begin
          r_overflow <= 1'b1;
          if (r_count != CNT_SAT) begin
            r_count <= r_count + cnt_t'(1);
          end
        end
      end
    end
  end

  assign out_data    = r_data;
  assign out_is_left = r_is_left;
  assign out_valid   = r_valid;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_audio_serial_receiver.sv
// Directed bench for audio_serial_receiver: bit-level serial stimulus, expected
// samples queued at issue time and checked by an independent output monitor.
module tb_audio_serial_receiver;
  import audio_serial_receiver_pkg::*;

  localparam int DW = 16;
  localparam int EW = DW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic lrclk = 1'b0;
  logic sclk = 1'b0;
  logic sdin = 1'b0;
  logic is_data_delay = 1'b0;
  logic lrclk_polarity = 1'b0;

  logic [DW-1:0] out_data;
  logic          out_is_left;
  logic          out_valid;
  logic          overflow;

  always #25 clk = ~clk;

  initial begin
    #(50 * 20000);
    $display("FAIL watchdog: simulation exceeded 20000 clk cycles, required completion");
    $fatal(1, "watchdog expired");
  end

  audio_serial_receiver #(
    .DATA_WIDTH  (DW),
    .SYNC_STAGES (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .lrclk          (lrclk),
    .sclk           (sclk),
    .sdin           (sdin),
    .is_data_delay  (is_data_delay),
    .lrclk_polarity (lrclk_polarity),
    .out_data       (out_data),
    .out_is_left    (out_is_left),
    .out_valid      (out_valid),
    .overflow       (overflow)
  );

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_exp;
  logic q_bit[$];
  logic q_lvl[$];

  always @(negedge clk) begin
    if (!reset && out_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_strobe: got data=%h left=%b, required no out_valid",
                 out_data, out_is_left);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({out_is_left, out_data} !== mon_exp) begin
          n_miss++;
          $display("FAIL sample: got data=%h left=%b, required data=%h left=%b",
                   out_data, out_is_left, mon_exp[DW-1:0], mon_exp[DW]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  task automatic expect_word(input logic [DW-1:0] d, input logic left);
    exp_q.push_back({left, d});
  endtask

  task automatic add_word(input logic [31:0] val, input int nbits, input logic lvl);
    for (int j = nbits - 1; j >= 0; j--) begin
      q_bit.push_back(val[j]);
      q_lvl.push_back(lvl);
    end
  endtask

  // In I2S framing lrclk leads the data by one slot.
  task automatic play();
    for (int i = 0; i < q_bit.size(); i++) begin
      sdin  = q_bit[i];
      lrclk = (is_data_delay && (i + 1 < q_bit.size())) ? q_lvl[i+1] : q_lvl[i];
      repeat (2) @(negedge clk);
      sclk = 1'b1;
      repeat (2) @(negedge clk);
      sclk = 1'b0;
    end
    q_bit.delete();
    q_lvl.delete();
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check({tag, "_rst_data"},  32'(out_data),    32'h0);
    check({tag, "_rst_left"},  32'(out_is_left), 32'h0);
    check({tag, "_rst_valid"}, 32'(out_valid),   32'h0);
    check({tag, "_rst_ovf"},   32'(overflow),    32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'h0);
  endtask

  // Three pre-frame bits, a 4-bit arming word 1010, then four 16-bit words.
  task automatic build_main();
    add_word(32'h0, 3, 1'b0);
    add_word(32'hA, 4, 1'b1);
    add_word(32'h0000, 16, 1'b0);
    add_word(32'h1FED, 16, 1'b1);
    add_word(32'h2EEF, 16, 1'b0);
    add_word(32'h3333, 16, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Left-justified, polarity 0
    is_data_delay  = 1'b0;
    lrclk_polarity = 1'b0;
    do_reset("lj0");
    expect_word(16'hA000, 1'b0);
    expect_word(16'h0000, 1'b1);
    expect_word(16'h1FED, 1'b0);
    expect_word(16'h2EEF, 1'b1);
    build_main();
    play();
    check_drained("lj0");
    check("lj0_hold_data", 32'(out_data), 32'h2EEF);
    check("lj0_hold_left", 32'(out_is_left), 32'h1);
    check("lj0_ovf", 32'(overflow), 32'h0);

    // I2S framing
    is_data_delay = 1'b1;
    do_reset("i2s");
    expect_word(16'hA000, 1'b0);
    expect_word(16'h5555, 1'b1);
    expect_word(16'h8888, 1'b0);
    add_word(32'h0, 3, 1'b0);
    add_word(32'hA, 4, 1'b1);
    add_word(32'h5555, 16, 1'b0);
    add_word(32'h8888, 16, 1'b1);
    add_word(32'h0, 2, 1'b0);
    play();
    check_drained("i2s");
    check("i2s_hold_data", 32'(out_data), 32'h8888);

    // Left-justified, polarity 1: same data, channels swapped
    is_data_delay  = 1'b0;
    lrclk_polarity = 1'b1;
    do_reset("lj1");
    expect_word(16'hA000, 1'b1);
    expect_word(16'h0000, 1'b0);
    expect_word(16'h1FED, 1'b1);
    expect_word(16'h2EEF, 1'b0);
    build_main();
    play();
    check_drained("lj1");
    check("lj1_hold_left", 32'(out_is_left), 32'h0);

    // Short then long words, then idle
    lrclk_polarity = 1'b0;
    do_reset("len");
    expect_word(16'hA000, 1'b0);
    expect_word(16'hA500, 1'b1);
    add_word(32'h0, 3, 1'b0);
    add_word(32'hA, 4, 1'b1);
    add_word(32'hA5, 8, 1'b0);
    play();
    check("short_ovf", 32'(overflow), 32'h0);
    expect_word(16'h1234, 1'b0);
    add_word(32'h123456, 24, 1'b1);
    play();
    check("long_ovf", 32'(overflow), 32'h1);
    add_word(32'h0, 2, 1'b0);
    play();
    check_drained("len");
    check("long_data", 32'(out_data), 32'h1234);
    check("long_ovf_sticky", 32'(overflow), 32'h1);
    for (int i = 0; i < 64; i++) begin
      q_bit.push_back(1'($urandom_range(0, 1)));
      q_lvl.push_back(1'b0);
    end
    play();
    check_drained("idle");
    check("idle_data", 32'(out_data), 32'h1234);
    check("idle_left", 32'(out_is_left), 32'h0);
    check("idle_ovf", 32'(overflow), 32'h1);

    // Reset in the middle of R = 0x1111
    do_reset("mid");
    expect_word(16'hA000, 1'b0);
    expect_word(16'h2222, 1'b1);
    add_word(32'h0, 3, 1'b0);
    add_word(32'hA, 4, 1'b1);
    add_word(32'h2222, 16, 1'b0);
    add_word(32'h11, 8, 1'b1);
    play();
    check_drained("pre_mid");
    check("pre_mid_data", 32'(out_data), 32'h2222);
    do_reset("midword");
    expect_word(16'h1100, 1'b0);
    expect_word(16'h3333, 1'b1);
    add_word(32'h11, 8, 1'b1);
    add_word(32'h3333, 16, 1'b0);
    add_word(32'h4, 4, 1'b1);
    play();
    check_drained("post_mid");
    check("post_mid_data", 32'(out_data), 32'h3333);
    check("post_mid_left", 32'(out_is_left), 32'h1);

    // ---------------- report ----------------
    check_drained("final");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
